// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback (port A) always wins, long-latency
// results (port B) queue in a 2-entry FIFO and drain on idle cycles, with a busy scoreboard.
module wb_port_arbiter #(
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_we_i,
  input  logic [4:0]    a_waddr_i,
  input  logic [DW-1:0] a_wdata_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  logic [4:0]    b_waddr_i,
  input  logic [DW-1:0] b_wdata_i,
  input  logic          iss_valid_i,
  input  logic [4:0]    iss_rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [4:0]    rd_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o,
  output logic          rd_busy_o,
  output logic          stall_o,
  output logic [1:0]    pend_cnt_o,
  output logic [4:0]    rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o
);

  logic [4:0]    waddr_mem [2];
  logic [DW-1:0] wdata_mem [2];
  logic          rd_ptr_reg, wr_ptr_reg;
  logic [1:0]    count_reg;
  logic [31:0]   busy_reg, busy_next;
  logic [7:0]    starve_reg, starve_next;
  logic          stall_reg;

  logic          a_active, accept, drain;
  logic [4:0]    head_waddr;
  logic [DW-1:0] head_wdata;

  assign a_active   = a_we_i && (a_waddr_i != 5'd0);
  assign b_ready_o  = (count_reg != 2'd2);
  assign accept     = b_valid_i && b_ready_o;
  assign drain      = !a_active && (count_reg != 2'd0);
  assign head_waddr = waddr_mem[rd_ptr_reg];
  assign head_wdata = wdata_mem[rd_ptr_reg];

  always_comb begin
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    if (a_active) begin
      rf_waddr_o = a_waddr_i;
      rf_wdata_o = a_wdata_i;
    end else if (drain) begin
      rf_waddr_o = head_waddr;
      rf_wdata_o = head_wdata;
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      waddr_mem[wr_ptr_reg] <= b_waddr_i;
      wdata_mem[wr_ptr_reg] <= b_wdata_i;
    end
  end

  // Issue is applied after drain so a same-cycle set on the same register wins.
  always_comb begin
    busy_next = busy_reg;
    if (drain)
      busy_next[head_waddr] = 1'b0;
    if (iss_valid_i)
      busy_next[iss_rd_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = starve_reg;
    if (drain || count_reg == 2'd0)
      starve_next = 8'd0;
    else if (starve_reg != 8'hFF)
      starve_next = starve_reg + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      busy_reg   <= '0;
      starve_reg <= 8'd0;
      stall_reg  <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (drain)  rd_ptr_reg <= ~rd_ptr_reg;
      unique case ({accept, drain})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      busy_reg   <= busy_next;
      starve_reg <= starve_next;
      if (drain)
        stall_reg <= 1'b0;
      else if (starve_next == 8'(STARVE_LIMIT))
        stall_reg <= 1'b1;
    end
  end

  assign rs1_busy_o = busy_reg[rs1_i];
  assign rs2_busy_o = busy_reg[rs2_i];
  assign rd_busy_o  = busy_reg[rd_i];
  assign stall_o    = stall_reg;
  assign pend_cnt_o = count_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for back-pressure, starvation and mid-operation reset.
module tb_wb_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_we_i, b_valid_i, iss_valid_i;
  logic [4:0]  a_waddr_i, b_waddr_i, iss_rd_i, rs1_i, rs2_i, rd_i;
  logic [31:0] a_wdata_i, b_wdata_i;
  logic        b_ready_o, rs1_busy_o, rs2_busy_o, rd_busy_o, stall_o;
  logic [1:0]  pend_cnt_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_port_arbiter #(.DW(32), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_we_i(a_we_i), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
    .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .rd_busy_o(rd_busy_o),
    .stall_o(stall_o), .pend_cnt_o(pend_cnt_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  typedef struct packed {
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1, rs2, rd;
    logic        e_ready;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [1:0]  e_pend;
    logic        e_rs1, e_rs2, e_rd, e_stall;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic aw, input logic [4:0] awa, input logic [31:0] awd,
    input logic bv, input logic [4:0] bwa, input logic [31:0] bwd,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
    input logic erdy, input logic [4:0] ewa, input logic [31:0] ewd, input logic [1:0] ep,
    input logic eb1, input logic eb2, input logic ebd, input logic est);
    vec_t v;
    v.a_we = aw; v.a_waddr = awa; v.a_wdata = awd;
    v.b_valid = bv; v.b_waddr = bwa; v.b_wdata = bwd;
    v.iss_valid = iv; v.iss_rd = ird;
    v.rs1 = r1; v.rs2 = r2; v.rd = rdd;
    v.e_ready = erdy; v.e_waddr = ewa; v.e_wdata = ewd; v.e_pend = ep;
    v.e_rs1 = eb1; v.e_rs2 = eb2; v.e_rd = ebd; v.e_stall = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic aw, input logic [4:0] awa, input logic [31:0] awd,
                       input logic bv, input logic [4:0] bwa, input logic [31:0] bwd);
    @(negedge clk_i);
    a_we_i = aw; a_waddr_i = awa; a_wdata_i = awd;
    b_valid_i = bv; b_waddr_i = bwa; b_wdata_i = bwd;
    iss_valid_i = 1'b0; iss_rd_i = 5'd0;
    #1;
  endtask

  task automatic chk_port(input string tag, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [1:0] pend, input logic rdy, input logic st);
    chk({tag, ".waddr"}, 32'(rf_waddr_o), 32'(wa));
    chk({tag, ".wdata"}, rf_wdata_o, wd);
    chk({tag, ".pend"}, 32'(pend_cnt_o), 32'(pend));
    chk({tag, ".ready"}, 32'(b_ready_o), 32'(rdy));
    chk({tag, ".stall"}, 32'(stall_o), 32'(st));
    $display("txn %s: waddr=%0d wdata=0x%0h pend=%0d ready=%0b stall=%0b",
             tag, rf_waddr_o, rf_wdata_o, pend_cnt_o, b_ready_o, stall_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    a_we_i = 0; a_waddr_i = 0; a_wdata_i = 0;
    b_valid_i = 0; b_waddr_i = 0; b_wdata_i = 0;
    iss_valid_i = 0; iss_rd_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;

    vecs[0]  = mk(0,0,0,            0,0,0,            0,0, 0,0,0, 1,0,0,0,            0,0,0,0);
    vecs[1]  = mk(1,5,32'h1234,     1,7,32'hBEEF,     0,0, 0,0,0, 1,5,32'h1234,0,     0,0,0,0);
    vecs[2]  = mk(0,0,0,            0,0,0,            0,0, 0,0,0, 1,7,32'hBEEF,1,     0,0,0,0);
    vecs[3]  = mk(0,0,0,            0,0,0,            0,0, 0,0,0, 1,0,0,0,            0,0,0,0);
    vecs[4]  = mk(0,0,0,            0,0,0,            1,9, 9,0,0, 1,0,0,0,            0,0,0,0);
    vecs[5]  = mk(0,0,0,            1,9,32'h99,       0,0, 9,9,9, 1,0,0,0,            1,1,1,0);
    vecs[6]  = mk(0,0,0,            0,0,0,            0,0, 9,0,0, 1,9,32'h99,1,       1,0,0,0);
    vecs[7]  = mk(0,0,0,            0,0,0,            0,0, 9,0,0, 1,0,0,0,            0,0,0,0);
    vecs[8]  = mk(0,0,0,            0,0,0,            1,0, 0,0,0, 1,0,0,0,            0,0,0,0);
    vecs[9]  = mk(0,0,0,            0,0,0,            0,0, 0,9,0, 1,0,0,0,            0,0,0,0);
    vecs[10] = mk(0,0,0,            0,0,0,            1,4, 0,0,4, 1,0,0,0,            0,0,0,0);
    vecs[11] = mk(0,0,0,            1,4,32'h44,       0,0, 0,0,4, 1,0,0,0,            0,0,1,0);
    vecs[12] = mk(0,0,0,            0,0,0,            1,4, 0,0,4, 1,4,32'h44,1,       0,0,1,0);
    vecs[13] = mk(0,0,0,            0,0,0,            0,0, 0,0,4, 1,0,0,0,            0,0,1,0);
    vecs[14] = mk(0,0,0,            1,4,32'h45,       0,0, 0,0,4, 1,0,0,0,            0,0,1,0);
    vecs[15] = mk(0,0,0,            0,0,0,            0,0, 0,0,4, 1,4,32'h45,1,       0,0,1,0);
    vecs[16] = mk(0,0,0,            0,0,0,            0,0, 0,0,4, 1,0,0,0,            0,0,0,0);
    vecs[17] = mk(0,0,0,            1,0,32'hDEAD,     0,0, 0,0,0, 1,0,0,0,            0,0,0,0);
    vecs[18] = mk(0,0,0,            0,0,0,            0,0, 0,0,0, 1,0,32'hDEAD,1,     0,0,0,0);
    vecs[19] = mk(0,0,0,            0,0,0,            0,0, 0,0,0, 1,0,0,0,            0,0,0,0);
    vecs[20] = mk(1,0,32'hAAAA,     1,11,32'hB1,      0,0, 0,0,0, 1,0,0,0,            0,0,0,0);
    vecs[21] = mk(1,0,32'hAAAA,     0,0,0,            0,0, 0,0,0, 1,11,32'hB1,1,      0,0,0,0);
    vecs[22] = mk(0,0,0,            0,0,0,            0,0, 0,0,0, 1,0,0,0,            0,0,0,0);

    // Reset state, checked while reset is held.
    #12;
    chk("reset.pend", 32'(pend_cnt_o), 0);
    chk("reset.ready", 32'(b_ready_o), 1);
    chk("reset.stall", 32'(stall_o), 0);
    chk("reset.waddr", 32'(rf_waddr_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      a_we_i = vecs[i].a_we; a_waddr_i = vecs[i].a_waddr; a_wdata_i = vecs[i].a_wdata;
      b_valid_i = vecs[i].b_valid; b_waddr_i = vecs[i].b_waddr; b_wdata_i = vecs[i].b_wdata;
      iss_valid_i = vecs[i].iss_valid; iss_rd_i = vecs[i].iss_rd;
      rs1_i = vecs[i].rs1; rs2_i = vecs[i].rs2; rd_i = vecs[i].rd;
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(b_ready_o),  32'(vecs[i].e_ready));
      chk($sformatf("vec%0d.waddr", i), 32'(rf_waddr_o), 32'(vecs[i].e_waddr));
      chk($sformatf("vec%0d.wdata", i), rf_wdata_o,      vecs[i].e_wdata);
      chk($sformatf("vec%0d.pend", i),  32'(pend_cnt_o), 32'(vecs[i].e_pend));
      chk($sformatf("vec%0d.rs1", i),   32'(rs1_busy_o), 32'(vecs[i].e_rs1));
      chk($sformatf("vec%0d.rs2", i),   32'(rs2_busy_o), 32'(vecs[i].e_rs2));
      chk($sformatf("vec%0d.rd", i),    32'(rd_busy_o),  32'(vecs[i].e_rd));
      chk($sformatf("vec%0d.stall", i), 32'(stall_o),    32'(vecs[i].e_stall));
      $display("txn vec%0d: waddr=%0d wdata=0x%0h pend=%0d ready=%0b busy=%0b%0b%0b stall=%0b",
               i, rf_waddr_o, rf_wdata_o, pend_cnt_o, b_ready_o,
               rs1_busy_o, rs2_busy_o, rd_busy_o, stall_o);
    end
    rs1_i = 0; rs2_i = 0; rd_i = 0;

    // Back-pressure: three results while port A holds the write port.
    drive(1, 10, 32'hA0, 1, 1, 32'h11);  chk_port("bp0", 10, 32'hA0, 0, 1, 0);
    drive(1, 10, 32'hA1, 1, 2, 32'h22);  chk_port("bp1", 10, 32'hA1, 1, 1, 0);
    drive(1, 10, 32'hA2, 1, 3, 32'h33);  chk_port("bp2", 10, 32'hA2, 2, 0, 0);
    drive(0, 0, 0,       1, 3, 32'h33);  chk_port("bp3", 1, 32'h11, 2, 0, 0);
    drive(0, 0, 0,       1, 3, 32'h33);  chk_port("bp4", 2, 32'h22, 1, 1, 0);
    drive(0, 0, 0,       0, 0, 0);       chk_port("bp5", 3, 32'h33, 1, 1, 0);
    drive(0, 0, 0,       0, 0, 0);       chk_port("bp6", 0, 0, 0, 1, 0);

    // Starvation: one entry held behind port A for eight undrained cycles.
    drive(1, 12, 32'hC0, 1, 6, 32'h66);  chk_port("sv0", 12, 32'hC0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 12, 32'hC0 + 32'(k), 0, 0, 0);
      chk_port($sformatf("sv%0d", k), 12, 32'hC0 + 32'(k), 1, 1, 0);
    end
    drive(1, 12, 32'hC9, 0, 0, 0);       chk_port("sv9", 12, 32'hC9, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0);             chk_port("sv10", 6, 32'h66, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0);             chk_port("sv11", 0, 0, 0, 1, 0);

    // Reset mid-operation with two buffered entries and x3 busy.
    drive(1, 13, 32'hD0, 1, 3, 32'h333);
    iss_valid_i = 1'b1; iss_rd_i = 5'd3; #1;
    drive(1, 13, 32'hD1, 1, 8, 32'h888);
    drive(1, 13, 32'hD2, 0, 0, 0);
    rd_i = 5'd3; #1;
    chk_port("rs0", 13, 32'hD2, 2, 0, 0);
    chk("rs0.rd_busy", 32'(rd_busy_o), 1);
    #2;
    rst_i = 1'b0; a_we_i = 1'b0; a_waddr_i = 0; a_wdata_i = 0;
    #1;
    chk_port("rs1", 0, 0, 0, 1, 0);
    chk("rs1.rd_busy", 32'(rd_busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk_port($sformatf("rs%0d", k + 2), 0, 0, 0, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single regfile write port between the in-order pipeline writeback (port A) and a long-latency result source such as a divider or load unit (port B).
- Port B results go through a 2-entry buffer. They drain whenever port A leaves the write port idle.
- A 32-bit scoreboard tracks registers with outstanding port-B writes, so issue logic can stall on RAW/WAW hazards.
- Sits between EX/WB and the regfile. The regfile has no write enable, so an idle write port is expressed as a write to x0.

Parameters:
DW, 32, data width; equals the codebase RegW.
STARVE_LIMIT, 8, consecutive undrained cycles of the buffer head before stall_o asserts; legal range 1..255.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
a_we_i  in  1  pipeline writeback valid; never back-pressured
a_waddr_i  in  5  pipeline destination register
a_wdata_i  in  DW  pipeline writeback data
b_valid_i  in  1  long-latency result valid
b_ready_o  out  1  buffer can accept a port-B result
b_waddr_i  in  5  long-latency destination register
b_wdata_i  in  DW  long-latency result data
iss_valid_i  in  1  long-latency op issued this cycle
iss_rd_i  in  5  destination register of the issued op
rs1_i  in  5  hazard-check source 1
rs2_i  in  5  hazard-check source 2
rd_i  in  5  hazard-check destination
rs1_busy_o  out  1  rs1_i has an outstanding port-B write
rs2_busy_o  out  1  rs2_i has an outstanding port-B write
rd_busy_o  out  1  rd_i has an outstanding port-B write
stall_o  out  1  starvation stall request to the pipeline
pend_cnt_o  out  2  buffer occupancy, 0..2
rf_waddr_o  out  5  to regfile waddr_i
rf_wdata_o  out  DW  to regfile wdata_i

Behaviour:
Reset (rst_i=0, asynchronous, legal at any time, including mid-operation):
- Buffer emptied; pend_cnt_o=0.
- All 32 busy bits cleared.
- Starvation counter cleared; stall_o=0.
- Buffered data is discarded.
- Combinational outputs follow from the cleared state: b_ready_o=1, rf_waddr_o=0, rf_wdata_o=0 when a_we_i=0.

A-active definition:
- A-active = a_we_i & (a_waddr_i!=0).

Write-port mux (combinational):
- A-active: rf_waddr_o/rf_wdata_o = port A.
- Else, buffer non-empty: drive the head entry and dequeue it at the clock edge (a "drain").
- Else: rf_waddr_o=0, rf_wdata_o=0.
- Port A always wins. Port A data is never delayed or dropped, including while stall_o=1.

Buffer:
- 2-entry FIFO; b_ready_o = (pend_cnt_o<2), combinational from state only.
- Accept when b_valid_i & b_ready_o; the entry is written at that edge.
- No same-cycle bypass. Minimum latency: accepted in cycle N, drives the write port in cycle N+1 at the earliest.
- Simultaneous accept and drain: occupancy unchanged, FIFO order kept.
- b_waddr_i=0 is accepted and drained normally (harmless write to x0); it has no scoreboard effect.

Scoreboard (busy[31:1]; busy[0] hard-wired 0):
- Set: iss_valid_i & iss_rd_i!=0 sets busy[iss_rd_i] at the edge.
- Clear: a drain clears busy[head waddr] at the edge.
- Set and clear of the same register in one cycle: set wins. The issuing op is newer, and the issue stage must not issue when rd_busy_o=1.
- rs1_busy_o, rs2_busy_o, rd_busy_o = busy[index], combinational; 0 for index 0.
- After a drain edge the busy bit reads 0 and the regfile holds the new value. No forwarding is required.

Starvation:
- 8-bit counter increments each cycle the buffer is non-empty and no drain occurs.
- Counter clears on a drain or when the buffer is empty.
- stall_o is registered: set at the edge where the counter reaches STARVE_LIMIT, held until the edge of the next drain.
- Pipeline contract: a_we_i=0 from the cycle after stall_o rises until it falls.
- If A-active occurs during stall_o=1, port A still wins and the stall persists.

Test Plan:
- Reset then idle, a_we_i=0 -> rf_waddr_o=0, rf_wdata_o=0, b_ready_o=1, pend_cnt_o=0, all busy outputs 0.
- a_we_i=1, a_waddr_i=5, a_wdata_i=0x1234 while b_valid_i=1 with waddr 7, data 0xBEEF -> cycle 0 writes x5=0x1234; cycle 1 (A idle) writes x7=0xBEEF; pend_cnt_o 1 then 0.
- iss_valid_i with iss_rd_i=9 -> rs1_i=9 gives rs1_busy_o=1 from the next cycle; B result for x9 accepted and drained -> busy clears the cycle after the drain; iss_rd_i=0 -> no busy bit set.
- Three back-to-back B results with A-active throughout -> b_ready_o drops after the 2nd acceptance; 3rd held with b_valid_i high; order preserved on drain (x1, x2, x3).
- A-active every cycle with 1 buffered entry, STARVE_LIMIT=8 -> stall_o=1 after 8 undrained cycles; A idles -> entry drains; stall_o=0 the following cycle.
- Assert rst_i low with 2 entries buffered and busy[3]=1 -> immediately pend_cnt_o=0, rd_busy_o=0 for rd_i=3, stall_o=0; the buffered entries are never written.
